decode_stage: RTL

- Registered RV32IMA instruction decode stage between fetch and execute.
- Consumes raw 32-bit instruction words over a valid/ready handshake.
- Classifies each word by the team's opcode, funct3, funct5 and funct7 encodings, extracts register indices and the sign-extended immediate, selects the ALU operation code, and flags illegal encodings.
- Splits AMO read-modify-write instructions into two micro-op beats.

---
 rtl/decode_stage.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// Purpose: registered RV32IMA decode between fetch and execute; AMO read-modify-write split into two beats.
// Latency: 1 cycle from accepted word to decoded beat; AMO adds a second beat right after the first fires.
// Backpressure: in_ready_o drops while a held beat is stalled, during the AMO second beat, or on flush_i.
// Ports: clk/rst_n (async active-low); flush_i kills held and pending beats;
//        in_valid_i/in_ready_o/in_instr_i/in_pc_i word input; out_valid_o/out_ready_i
//        decoded beat handshake with pc, opcode, funct3, rd/rs1/rs2, imm, alu_sel, fmt,
//        mul, atomic, uop, we_rd and illegal fields.
module decode_stage #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC_TAG = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_instr_i,
  input  logic [XLEN-1:0] in_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_pc_o,
  output logic [6:0]      out_opcode_o,
  output logic [2:0]      out_funct3_o,
  output logic [4:0]      out_rd_o,
  output logic [4:0]      out_rs1_o,
  output logic [4:0]      out_rs2_o,
  output logic [31:0]     out_imm_o,
  output logic [3:0]      out_alu_sel_o,
  output logic [2:0]      out_fmt_o,
  output logic            out_mul_o,
  output logic            out_atomic_o,
  output logic            out_uop_o,
  output logic            out_we_rd_o,
  output logic            out_illegal_o
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_AMO    = 7'b0101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;
  localparam logic [4:0] F5_LR   = 5'b00010;
  localparam logic [4:0] F5_SC   = 5'b00011;

  localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4, FMT_J = 3'd5, FMT_NONE = 3'd7;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000, ALU_SLL = 4'b0001, ALU_SLT = 4'b0010, ALU_SLTU = 4'b0011,
    ALU_XOR = 4'b0100, ALU_SRL = 4'b0101, ALU_OR  = 4'b0110, ALU_AND  = 4'b0111,
    ALU_SUB = 4'b1000, ALU_SRA = 4'b1101
  } alu_sel_t;

  typedef enum logic {IDLE, AMO_2} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [31:0]     imm;
    alu_sel_t        alu_sel;
    logic [2:0]      fmt;
    logic            mul;
    logic            atomic;
    logic            uop;
    logic            we_rd;
    logic            illegal;
  } beat_t;

  state_t state;
  beat_t  out_q;
  logic   out_q_vld;
  beat_t  dec;
  logic   dec_split;
  logic   f5_ok;

  wire [6:0]  opcode = in_instr_i[6:0];
  wire [2:0]  f3     = in_instr_i[14:12];
  wire [6:0]  f7     = in_instr_i[31:25];
  wire [4:0]  f5     = in_instr_i[31:27];
  wire [31:0] imm_i  = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
  wire [31:0] imm_s  = {{20{in_instr_i[31]}}, in_instr_i[31:25], in_instr_i[11:7]};
  wire [31:0] imm_b  = {{19{in_instr_i[31]}}, in_instr_i[31], in_instr_i[7],
                        in_instr_i[30:25], in_instr_i[11:8], 1'b0};
  wire [31:0] imm_u  = {in_instr_i[31:12], 12'b0};
  wire [31:0] imm_j  = {{11{in_instr_i[31]}}, in_instr_i[31], in_instr_i[19:12],
                        in_instr_i[20], in_instr_i[30:21], 1'b0};

  wire out_fire = out_q_vld && out_ready_i;
  assign in_ready_o = !flush_i && (state == IDLE) && (!out_q_vld || out_ready_i);
  wire accept   = in_valid_i && in_ready_o;

  always_comb begin
    f5_ok = 1'b0;
    case (f5)
      5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b01000,
      5'b01100, 5'b10000, 5'b10100, 5'b11000, 5'b11100: f5_ok = 1'b1;
      default: f5_ok = 1'b0;
    endcase
  end

  // Combinational decode of the incoming word; unknown fields stay zero.
  always_comb begin
    dec         = '0;
    dec_split   = 1'b0;
    dec.pc      = in_pc_i;
    dec.opcode  = opcode;
    dec.funct3  = f3;
    dec.rd      = in_instr_i[11:7];
    dec.rs1     = in_instr_i[19:15];
    dec.rs2     = in_instr_i[24:20];
    dec.fmt     = FMT_NONE;
    dec.alu_sel = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        dec.fmt = FMT_R;
        case (f7)
          F7_BASE: dec.alu_sel = alu_sel_t'({in_instr_i[30], f3});
          F7_ALT: begin
            dec.alu_sel = alu_sel_t'({in_instr_i[30], f3});
            // only SUB and SRA use the alternate funct7
            dec.illegal = (f3 != 3'b000) && (f3 != 3'b101);
          end
          F7_MUL:  dec.mul = 1'b1;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_IMM: begin
        dec.fmt     = FMT_I;
        dec.imm     = imm_i;
        dec.alu_sel = alu_sel_t'({(f3 == 3'b101) && in_instr_i[30], f3});
        if (f3 == 3'b001 && f7 != F7_BASE)
          dec.illegal = 1'b1;
        if (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT)
          dec.illegal = 1'b1;
      end
      OPC_LOAD: begin
        dec.fmt     = FMT_I;
        dec.imm     = imm_i;
        dec.illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        dec.fmt     = FMT_S;
        dec.imm     = imm_s;
        dec.illegal = (f3 >= 3'b011);
      end
      OPC_BRANCH: begin
        dec.fmt     = FMT_B;
        dec.imm     = imm_b;
        dec.illegal = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_JALR: begin
        dec.fmt     = FMT_I;
        dec.imm     = imm_i;
        dec.illegal = (f3 != 3'b000);
      end
      OPC_JAL: begin
        dec.fmt = FMT_J;
        dec.imm = imm_j;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.fmt = FMT_U;
        dec.imm = imm_u;
      end
      OPC_MISC, OPC_SYSTEM: begin
        dec.fmt = FMT_I;
        dec.imm = imm_i;
      end
      OPC_AMO: begin
        dec.fmt     = FMT_R;
        dec.atomic  = 1'b1;
        dec.illegal = (f3 != 3'b010) || !f5_ok || (f5 == F5_LR && dec.rs2 != 5'd0);
        // LR and SC are single-beat; every other legal AMO is read then write
        dec_split   = !dec.illegal && (f5 != F5_LR) && (f5 != F5_SC);
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.we_rd = !(dec.illegal || opcode == OPC_BRANCH || opcode == OPC_STORE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_q_vld <= 1'b0;
      out_q     <= '0;
      out_q.fmt <= FMT_NONE;
      out_q.pc  <= RESET_PC_TAG;
    end else if (flush_i) begin
      // flush wins over a simultaneous fire and drops any pending AMO write beat
      state     <= IDLE;
      out_q_vld <= 1'b0;
      out_q.pc  <= RESET_PC_TAG;
    end else if (accept) begin
      out_q     <= dec;
      out_q_vld <= 1'b1;
      state     <= dec_split ? AMO_2 : IDLE;
    end else if (out_fire) begin
      if (state == AMO_2) begin
        out_q.uop   <= 1'b1;
        out_q.we_rd <= 1'b0;
        state       <= IDLE;
      end else begin
        out_q_vld <= 1'b0;
        out_q.pc  <= RESET_PC_TAG;
      end
    end
  end

  assign out_valid_o   = out_q_vld;
  assign out_pc_o      = out_q.pc;
  assign out_opcode_o  = out_q.opcode;
  assign out_funct3_o  = out_q.funct3;
  assign out_rd_o      = out_q.rd;
  assign out_rs1_o     = out_q.rs1;
  assign out_rs2_o     = out_q.rs2;
  assign out_imm_o     = out_q.imm;
  assign out_alu_sel_o = out_q.alu_sel;
  assign out_fmt_o     = out_q.fmt;
  assign out_mul_o     = out_q.mul;
  assign out_atomic_o  = out_q.atomic;
  assign out_uop_o     = out_q.uop;
  assign out_we_rd_o   = out_q.we_rd;
  assign out_illegal_o = out_q.illegal;

endmodule
